err_log_arbiter: RTL
====================

# err_log_arbiter

Collects error events from up to NUM_SRC error sources, arbitrates them one per cycle (fatal first, otherwise round-robin) and writes them into an event log FIFO. Firmware or a downstream alert/interrupt block drains the FIFO through a valid/ready port. The block sits beside the error threshold monitor: same per-source error_valid/severity inputs, but it preserves event order and identity rather than counts. Overflow is lossy and counted, because sources emit pulses and cannot be back-pressured.

## Interface
- NUM_SRC, 8, number of error sources (2..32)
- CODE_W, 8, width of per-source error code
- DEPTH, 16, log FIFO depth, power of 2, ≥2
- TS_W, 16, timestamp width (used only with the macro)
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- enable  input  1  arbitration enable; log drain is unaffected
- src_req  input  NUM_SRC  per-source event request, level, held until acked
- src_sev  input  2×NUM_SRC  severity: 0 info, 1 warn, 2 error, 3 fatal
- src_code  input  CODE_W×NUM_SRC  per-source error code
- src_ack  output  NUM_SRC  one-cycle, one-hot acknowledge
- log_valid  output  1  FIFO head valid (equals !log_empty)
- log_ready  input  1  consumer pops the head when log_valid && log_ready
- log_src  output  $clog2(NUM_SRC)  head source index
- log_sev  output  2  head severity
- log_code  output  CODE_W  head code
- log_ts  output  TS_W  head timestamp (present only with the macro)
- log_count  output  $clog2(DEPTH)+1  FIFO occupancy
- log_full / log_empty  output  1  occupancy flags
- overflow_cnt  output  16  count of dropped events, saturating
- drop_flag  output  1  sticky: at least one event dropped
- clr_overflow  input  1  synchronous clear of overflow_cnt and drop_flag
- fatal_pending  output  1  at least one severity-3 entry in the FIFO

## Operation
- Eligible sources: src_req[i] && !src_ack[i]. A source whose ack is high this cycle is masked, so it is not re-granted on its stale request.
- Arbitration is combinational from eligible and the sampled sev and code, gated by enable.
  - If any eligible source has sev==3, round-robin runs among fatal sources only.
  - Otherwise round-robin runs among all eligible sources.
- Round-robin search starts at last_grant+1 and wraps at NUM_SRC. last_grant updates on every grant. It resets to NUM_SRC-1, so source 0 has first priority.
- Grant effects at the next edge:
  - src_ack[g] is registered high for exactly one cycle.
  - An entry {g, sev, code[, ts]} is pushed into the FIFO.
- Source rule: deassert req in the cycle after ack. A req still high two cycles after its ack is treated as a new event.
- Push when full:
  - With a pop in the same cycle: both succeed and count is unchanged.
  - Without a pop: the entry is discarded but src_ack is still issued. overflow_cnt increments (saturates at 0xFFFF) and drop_flag is set.
- clr_overflow takes priority over a simultaneous increment: the result is 0 and the flag clears.
- fatal_pending is derived from a fatal-entry counter: +1 on each accepted push with sev 3, −1 on each pop of a head with sev 3, both applied in the same cycle when they coincide. fatal_pending = counter != 0, registered.
- enable low: no grants and no acks. Pending requests are simply held. FIFO pops continue.

## Timing
- Reset values:
  - src_ack=0, log_valid=0, log_empty=1, log_full=0, log_count=0.
  - log_src/sev/code/ts=0, overflow_cnt=0, drop_flag=0, fatal_pending=0.
  - FIFO pointers and last_grant (NUM_SRC-1) are also reset.
- Req sampled in cycle N → src_ack and the FIFO write at edge N+1.
- FIFO is first-word-fall-through: an entry pushed into an empty FIFO gives log_valid=1 in cycle N+1.
- Pop at edge M: the next head (or log_valid=0) appears in cycle M+1.
- Throughput: one grant per cycle; NUM_SRC simultaneous requests drain in NUM_SRC cycles.
- FIFO pointers are $clog2(DEPTH)+1 bits and wrap naturally. full/empty are decoded from the MSB difference.
- Asserting rst_n mid-operation discards all entries and pending state immediately. Sources must re-request.

## Configuration
- ERR_LOG_TIMESTAMP_EN defined:
  - A free-running TS_W counter runs from reset 0 and wraps 2^TS_W−1→0.
  - Each entry captures the counter value from the grant cycle N.
  - log_ts is present.
- Undefined: no counter, no ts field in the FIFO storage, and no log_ts port.

## Structure
- Shared package err_mon_pkg holds:
  - severity enum err_sev_e (SEV_INFO, SEV_WARN, SEV_ERR, SEV_FATAL).
  - Entry struct err_log_entry_t, with the ts field under the macro.
  - Overflow counter width constant ERR_OVF_W=16.
- One sub-module, err_log_fifo: a parameterised FWFT synchronous FIFO with push, pop, count, full and empty. The arbiter, round-robin pointer, overflow and fatal counters live in err_log_arbiter.

## Test plan
- Reset: hold rst_n low, drive random inputs → all outputs at their reset values; log_empty=1; no src_ack.
- Sources 2 and 5 request sev 1 in the same cycle after reset → ack[2] at edge 1 and ack[5] at edge 2; log pops give src 2 then src 5.
- Source 1 at sev 1 and source 6 at sev 3 → source 6 is acked first and fatal_pending=1. After source 6's entry is popped → fatal_pending=0 one cycle later.
- log_ready=0, 19 single events → log_count=16, log_full=1, overflow_cnt=3, drop_flag=1. Then clr_overflow → both 0.
- FIFO full with a grant and log_ready=1 in the same cycle → log_count stays 16, overflow_cnt is unchanged, and the new entry is at the tail.
- With ERR_LOG_TIMESTAMP_EN, a request sampled when the counter reads 0x0005 → entry ts=0x0005. Run past 0xFFFF → ts wraps to 0x0000.

Source files
------------

// File: rtl/err_mon_pkg.sv
// Shared error-monitor types: severity encoding, reference log entry layout, overflow width.
// ERR_LOG_TIMESTAMP_EN adds a timestamp field to the log entry.
package err_mon_pkg;

  typedef enum logic [1:0] {
    SEV_INFO  = 2'd0,
    SEV_WARN  = 2'd1,
    SEV_ERR   = 2'd2,
    SEV_FATAL = 2'd3
  } err_sev_e;

  localparam int ERR_OVF_W  = 16;
  localparam int ERR_SRC_W  = 3;
  localparam int ERR_CODE_W = 8;
  localparam int ERR_TS_W   = 16;

  // Entry layout at the default widths; err_log_arbiter builds the same
  // field order at its own parameter widths.
  typedef struct packed {
    logic [ERR_SRC_W-1:0]  src;
    err_sev_e              sev;
    logic [ERR_CODE_W-1:0] code;
`ifdef ERR_LOG_TIMESTAMP_EN
    logic [ERR_TS_W-1:0]   ts;
`endif
  } err_log_entry_t;

endpackage

// File: rtl/err_log_fifo.sv
// First-word-fall-through synchronous FIFO; pointers carry one extra wrap bit.
module err_log_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic         do_push, do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count   = wptr - rptr;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted only if the head leaves in the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/err_log_arbiter.sv
// Fatal-first round-robin arbiter feeding an error event log FIFO with lossy, counted overflow.
// ERR_LOG_TIMESTAMP_EN adds a free-running timestamp captured per entry and the log_ts port.
module err_log_arbiter
  import err_mon_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int CODE_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TS_W    = 16,
  localparam int SRC_W  = $clog2(NUM_SRC),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic [NUM_SRC-1:0]              src_req,
  input  logic [NUM_SRC-1:0][1:0]         src_sev,
  input  logic [NUM_SRC-1:0][CODE_W-1:0]  src_code,
  output logic [NUM_SRC-1:0]              src_ack,
  output logic                            log_valid,
  input  logic                            log_ready,
  output logic [SRC_W-1:0]                log_src,
  output logic [1:0]                      log_sev,
  output logic [CODE_W-1:0]               log_code,
`ifdef ERR_LOG_TIMESTAMP_EN
  output logic [TS_W-1:0]                 log_ts,
`endif
  output logic [CNT_W-1:0]                log_count,
  output logic                            log_full,
  output logic                            log_empty,
  output logic [ERR_OVF_W-1:0]            overflow_cnt,
  output logic                            drop_flag,
  input  logic                            clr_overflow,
  output logic                            fatal_pending
);

  if (NUM_SRC < 2 || NUM_SRC > 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      CODE_W < 1 || TS_W < 1) begin : g_cfg_err
    $error("err_log_arbiter: unsupported parameter set");
  end

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    err_sev_e          sev;
    logic [CODE_W-1:0] code;
`ifdef ERR_LOG_TIMESTAMP_EN
    logic [TS_W-1:0]   ts;
`endif
  } entry_t;

  logic [NUM_SRC-1:0] elig, fatal_v, cand;
  logic [SRC_W-1:0]   last_grant, gnt_idx;
  logic               gnt_vld;
  logic               pop, push_ok, drop;
  logic [CNT_W-1:0]   fatal_cnt, fatal_cnt_nxt;
  entry_t             wr_entry, head;

`ifdef ERR_LOG_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_W'(1);
  end

  assign log_ts = head.ts;
`endif

  // A source acked this cycle is still showing its old request; mask it.
  always_comb begin
    elig    = src_req & ~src_ack;
    fatal_v = '0;
    for (int i = 0; i < NUM_SRC; i++)
      fatal_v[i] = elig[i] && (src_sev[i] == SEV_FATAL);
    cand = enable ? ((|fatal_v) ? fatal_v : elig) : '0;
  end

  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = int'(last_grant) + 1 + i;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!gnt_vld && cand[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    wr_entry      = '0;
    wr_entry.src  = gnt_idx;
    wr_entry.sev  = err_sev_e'(src_sev[gnt_idx]);
    wr_entry.code = src_code[gnt_idx];
`ifdef ERR_LOG_TIMESTAMP_EN
    wr_entry.ts   = ts_cnt;
`endif
  end

  assign pop     = log_valid && log_ready;
  assign push_ok = gnt_vld && (!log_full || pop);
  assign drop    = gnt_vld && log_full && !pop;

  err_log_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (gnt_vld),
    .wdata (wr_entry),
    .pop   (pop),
    .rdata (head),
    .count (log_count),
    .full  (log_full),
    .empty (log_empty)
  );

  assign log_valid = !log_empty;
  assign log_src   = head.src;
  assign log_sev   = head.sev;
  assign log_code  = head.code;

  always_comb begin
    fatal_cnt_nxt = fatal_cnt;
    if (push_ok && wr_entry.sev == SEV_FATAL) fatal_cnt_nxt = fatal_cnt_nxt + CNT_W'(1);
    if (pop && head.sev == SEV_FATAL)         fatal_cnt_nxt = fatal_cnt_nxt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ack       <= '0;
      last_grant    <= SRC_W'(NUM_SRC - 1);
      fatal_cnt     <= '0;
      fatal_pending <= 1'b0;
      overflow_cnt  <= '0;
      drop_flag     <= 1'b0;
    end else begin
      src_ack <= '0;
      if (gnt_vld) begin
        src_ack[gnt_idx] <= 1'b1;
        last_grant       <= gnt_idx;
      end
      fatal_cnt     <= fatal_cnt_nxt;
      fatal_pending <= (fatal_cnt_nxt != '0);
      // Clear wins over a same-cycle drop.
      if (clr_overflow) begin
        overflow_cnt <= '0;
        drop_flag    <= 1'b0;
      end else if (drop) begin
        if (overflow_cnt != '1) overflow_cnt <= overflow_cnt + ERR_OVF_W'(1);
        drop_flag <= 1'b1;
      end
    end
  end

endmodule
